// File: rtl/ram_arbiter.sv
// ram_arbiter: two request ports sharing one single-access RAM through an IDLE/OWN_A/OWN_B arbiter.
module ram_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_grant,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_grant,
  output logic [1:0]            D_OWNER,
  output logic [7:0]            D_DROPCNT
);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN_A = 2'b01, OWN_B = 2'b10} state_t;
  state_t state;
  logic last_b;
  logic req_a, req_b, a_wins;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;
  // a lone writer beats a reader; otherwise the port not served last wins
  assign a_wins = req_a & (~req_b | ((a_write ^ b_write) ? a_write : last_b));
  assign a_grant = state == OWN_A;
  assign b_grant = state == OWN_B;
  assign D_OWNER = state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      a_rdata   <= '0;
      b_rdata   <= '0;
      D_DROPCNT <= '0;
    end else begin
      if (state == IDLE && (req_a || req_b)) begin
        state  <= a_wins ? OWN_A : OWN_B;
        last_b <= ~a_wins;
      end else if ((a_grant && !req_a) || (b_grant && !req_b))
        state <= IDLE;
      if (a_grant && a_read && !a_write) a_rdata <= mem[a_addr];
      if (b_grant && b_read && !b_write) b_rdata <= mem[b_addr];
      if (((b_grant && a_write) || (a_grant && b_write)) && D_DROPCNT != 8'hFF)
        D_DROPCNT <= D_DROPCNT + 8'd1;
    end
  // RAM has no reset so its contents survive rst
  always_ff @(posedge clk)
    if (!rst && a_grant && a_write) mem[a_addr] <= a_wdata;
    else if (!rst && b_grant && b_write) mem[b_addr] <= b_wdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table plus hand sequences for saturation, bursts and reset.
module tb_ram_arbiter;
  logic clk = 0, rst = 1;
  logic [13:0] a_addr = 0, b_addr = 0;
  logic a_read = 0, a_write = 0, b_read = 0, b_write = 0;
  logic [9:0] a_wdata = 0, b_wdata = 0, a_rdata, b_rdata;
  logic a_grant, b_grant;
  logic [1:0] D_OWNER;
  logic [7:0] D_DROPCNT;
  int n_chk = 0, n_fail = 0;
  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_read(a_read), .a_write(a_write), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_grant(a_grant),
    .b_addr(b_addr), .b_read(b_read), .b_write(b_write), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_grant(b_grant),
    .D_OWNER(D_OWNER), .D_DROPCNT(D_DROPCNT)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ar, aw; logic [13:0] aa; logic [9:0] ad;
    logic br, bw; logic [13:0] ba; logic [9:0] bd;
    logic eag, ebg; logic [1:0] eown; logic [9:0] eard, ebrd; logic [7:0] edrop;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic ar, aw, logic [13:0] aa, logic [9:0] ad,
                             logic br, bw, logic [13:0] ba, logic [9:0] bd,
                             logic eag, ebg, logic [1:0] eown, logic [9:0] eard, ebrd,
                             logic [7:0] edrop);
    vec_t r;
    r.ar = ar; r.aw = aw; r.aa = aa; r.ad = ad; r.br = br; r.bw = bw; r.ba = ba; r.bd = bd;
    r.eag = eag; r.ebg = ebg; r.eown = eown; r.eard = eard; r.ebrd = ebrd; r.edrop = edrop;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic ar, aw, input logic [13:0] aa, input logic [9:0] ad,
                       input logic br, bw, input logic [13:0] ba, input logic [9:0] bd);
    a_read = ar; a_write = aw; a_addr = aa; a_wdata = ad;
    b_read = br; b_write = bw; b_addr = ba; b_wdata = bd;
  endtask
  function automatic logic [9:0] pat(input int i);
    return 10'(i * 7 + 3);
  endfunction
  initial begin
    // tie arbitration from reset: A, then B, then A again
    tbl.push_back(v(1,0,0,0,     1,0,0,0,       1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,     1,0,0,0,       0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,     1,0,0,0,       0,1,2,0,0,0));
    tbl.push_back(v(1,0,0,0,     0,0,0,0,       0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,     1,0,0,0,       1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,0,       0,0,0,0,0,0));
    // A writes two words then reads them back
    tbl.push_back(v(0,1,14'h40,10'h155, 0,0,0,0, 1,0,1,0,0,0));
    tbl.push_back(v(0,1,14'h40,10'h155, 0,0,0,0, 1,0,1,0,0,0));
    tbl.push_back(v(0,1,14'h41,10'h2AA, 0,0,0,0, 1,0,1,0,0,0));
    tbl.push_back(v(1,0,14'h40,0,  0,0,0,0,     1,0,1,10'h155,0,0));
    tbl.push_back(v(1,0,14'h41,0,  0,0,0,0,     1,0,1,10'h2AA,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,0,     0,0,0,10'h2AA,0,0));
    // B reads shared RAM, then write priority over a tie-favoured A
    tbl.push_back(v(0,0,0,0,   1,0,14'h40,0,    0,1,2,10'h2AA,0,0));
    tbl.push_back(v(0,0,0,0,   1,0,14'h40,0,    0,1,2,10'h2AA,10'h155,0));
    tbl.push_back(v(0,0,0,0,   0,0,0,0,         0,0,0,10'h2AA,10'h155,0));
    tbl.push_back(v(1,0,14'h41,0, 0,1,14'h100,10'h0F0, 0,1,2,10'h2AA,10'h155,0));
    tbl.push_back(v(1,0,14'h41,0, 0,1,14'h100,10'h0F0, 0,1,2,10'h2AA,10'h155,0));
    tbl.push_back(v(1,0,14'h41,0, 0,0,0,0,      0,0,0,10'h2AA,10'h155,0));
    tbl.push_back(v(1,0,14'h41,0, 0,0,0,0,      1,0,1,10'h2AA,10'h155,0));
    tbl.push_back(v(1,0,14'h100,0, 0,0,0,0,     1,0,1,10'h0F0,10'h155,0));
    tbl.push_back(v(1,1,14'h42,10'h3FF, 0,0,0,0, 1,0,1,10'h0F0,10'h155,0));
    tbl.push_back(v(1,0,14'h42,0,  0,0,0,0,     1,0,1,10'h3FF,10'h155,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,0,     0,0,0,10'h3FF,10'h155,0));
    step(); step();
    chk("rst a_grant", a_grant, 0);
    chk("rst b_grant", b_grant, 0);
    chk("rst owner", D_OWNER, 0);
    chk("rst a_rdata", a_rdata, 0);
    chk("rst b_rdata", b_rdata, 0);
    chk("rst dropcnt", D_DROPCNT, 0);
    rst = 0;
    step();
    chk("idle stays idle", D_OWNER, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd);
      step();
      chk($sformatf("v%0d a_grant", i), a_grant, tbl[i].eag);
      chk($sformatf("v%0d b_grant", i), b_grant, tbl[i].ebg);
      chk($sformatf("v%0d owner", i), D_OWNER, tbl[i].eown);
      chk($sformatf("v%0d a_rdata", i), a_rdata, tbl[i].eard);
      chk($sformatf("v%0d b_rdata", i), b_rdata, tbl[i].ebrd);
      chk($sformatf("v%0d dropcnt", i), D_DROPCNT, tbl[i].edrop);
    end
    // B owns while A hammers a write for 300 cycles
    drive(0,0,0,0, 1,0,14'h40,0);
    step();
    chk("sat b_grant", b_grant, 1);
    drive(0,1,14'h40,10'h000, 1,0,14'h40,0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 9) chk("sat drop10", D_DROPCNT, 10);
      if (i == 254) chk("sat drop255", D_DROPCNT, 255);
    end
    chk("sat hold", D_DROPCNT, 255);
    chk("sat b_rdata", b_rdata, 10'h155);
    chk("sat a_grant", a_grant, 0);
    drive(0,0,0,0, 0,0,0,0);
    step();
    drive(1,0,14'h40,0, 0,0,0,0);
    step(); step();
    chk("sat ram kept", a_rdata, 10'h155);
    // A: 32 writes then a 32-word read burst
    drive(0,1,14'h200,pat(0), 0,0,0,0);
    step();
    for (int i = 0; i < 32; i++) begin
      drive(0,1,14'(14'h200 + i),pat(i), 0,0,0,0);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1,0,14'(14'h200 + i),0, 0,0,0,0);
      step();
      if (i % 8 == 0 || i == 31) chk($sformatf("burst w%0d", i), a_rdata, pat(i));
    end
    chk("burst grant", a_grant, 1);
    drive(0,0,0,0, 0,0,0,0);
    #1;
    chk("burst tail grant", a_grant, 1);
    chk("burst tail data", a_rdata, pat(31));
    step();
    chk("burst released", a_grant, 0);
    chk("burst data held", a_rdata, pat(31));
    // reset in the middle of a B read burst with a write pending
    drive(0,0,0,0, 1,0,14'h40,0);
    step(); step(); step();
    chk("pre-rst b_rdata", b_rdata, 10'h155);
    drive(0,0,0,0, 1,1,14'h40,10'h0AA);
    rst = 1;
    #1;
    chk("rst mid b_grant", b_grant, 0);
    chk("rst mid b_rdata", b_rdata, 0);
    chk("rst mid owner", D_OWNER, 0);
    chk("rst mid dropcnt", D_DROPCNT, 0);
    step();
    chk("rst held owner", D_OWNER, 0);
    drive(0,0,0,0, 1,0,14'h40,0);
    rst = 0;
    step();
    chk("post-rst b_grant", b_grant, 1);
    step();
    chk("post-rst ram kept", b_rdata, 10'h155);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
